rom_burst_arbiter: RTL and testbench

Round-robin arbiter and burst sequencer that shares one single-port synchronous ROM (registered read, 1-cycle latency, read enable) among up to four requesters. Each requester asks for a burst of consecutive words from a base address. The block grants one requester at a time, drives the ROM enable and address for every word, and returns the tagged read data. It sits between the ROM and its consumers, and is the only driver of the ROM's enable and address inputs.

---
 rtl/rom_burst_arbiter_if.sv | 32 +++
 rtl/rom_burst_arbiter.sv | 178 +++++++++++++++++
 tb/tb_rom_burst_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rom_burst_arbiter_if.sv
// Bundle between the burst arbiter and its requesters, consumers and ROM.
// The slave side is the arbiter; the master side is everything around it.
interface rom_burst_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 3,
  parameter int DW   = 4,
  parameter int LW   = 3,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0]    req_ack;
  logic               rom_en;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;
  logic               rd_valid;
  logic [DW-1:0]      rd_data;
  logic [IDW-1:0]     rd_id;
  logic               rd_last;
  logic               busy;

  modport slave (
    input  req, req_addr, req_len, rom_data,
    output req_ack, rom_en, rom_addr, rd_valid, rd_data, rd_id, rd_last, busy
  );

  modport master (
    output req, req_addr, req_len, rom_data,
    input  req_ack, rom_en, rom_addr, rd_valid, rd_data, rd_id, rd_last, busy
  );
endinterface

// File: rtl/rom_burst_arbiter.sv
// Round-robin burst arbiter sharing one registered-read ROM among NREQ requesters.
// One burst at a time; one IDLE cycle between bursts; tagged data one cycle after rom_en.

// Per-requester priority lane: distance of this requester from the round-robin
// start point (ptr+1); the smallest distance among active requests wins.
module rba_rr_lane #(
  parameter int NREQ = 2,
  parameter int IDW  = 2,
  parameter int IDX  = 0
) (
  input  logic           i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic           o_hit,
  output logic [IDW-1:0] o_dist
);
  int w_d;

  always_comb begin
    w_d = IDX - int'(i_ptr) - 1;
    if (w_d < 0) w_d = w_d + NREQ;
  end

  assign o_hit  = i_req;
  assign o_dist = IDW'(w_d);
endmodule

module rom_burst_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 3,
  parameter int DW   = 4,
  parameter int LW   = 3,
  parameter int IDW  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  rom_burst_arbiter_if.slave  bus
);
  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t r_state, w_nxt_state;

  logic [IDW-1:0]  r_ptr;
  logic [AW-1:0]   r_cur_addr;
  logic [LW-1:0]   r_remaining;
  logic [IDW-1:0]  r_own_id;
  logic [NREQ-1:0] r_ack;
  logic            r_v1;
  logic [IDW-1:0]  r_id1;
  logic            r_last1;

  logic                      w_busy;
  logic                      w_rom_en;
  logic                      w_any;
  logic                      w_found;
  logic [IDW-1:0]            w_win;
  logic [IDW-1:0]            w_best;
  logic [AW-1:0]             w_win_addr;
  logic [LW-1:0]             w_win_len;
  logic                      w_grant;
  logic                      w_rem_zero;
  logic [NREQ-1:0]           w_hit;
  logic [NREQ-1:0][IDW-1:0]  w_dist;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_lane
      rba_rr_lane #(.NREQ(NREQ), .IDW(IDW), .IDX(g)) u_lane (
        .i_req  (bus.req[g]),
        .i_ptr  (r_ptr),
        .o_hit  (w_hit[g]),
        .o_dist (w_dist[g])
      );
    end
  endgenerate

  // Nearest active requester after ptr, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_best  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_hit[i] && (!w_found || (w_dist[i] < w_best))) begin
        w_found = 1'b1;
        w_win   = IDW'(i);
        w_best  = w_dist[i];
      end
    end
  end

  always_comb begin
    w_win_addr = '0;
    w_win_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_win_addr = bus.req_addr[i*AW +: AW];
        w_win_len  = bus.req_len[i*LW +: LW];
      end
    end
  end

  assign w_any      = |bus.req;
  assign w_rem_zero = (r_remaining == '0);
  assign w_grant    = (r_state == S_IDLE) && w_any && w_found;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nxt_state;
  end

  // Next-state logic
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE:  if (w_grant)    w_nxt_state = S_BURST;
      S_BURST: if (w_rem_zero) w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Output decode; all terms come straight from registered state.
  always_comb begin
    w_busy   = 1'b0;
    w_rom_en = 1'b0;
    case (r_state)
      S_BURST: begin
        w_busy   = 1'b1;
        w_rom_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Burst bookkeeping: latch the winner in IDLE, walk the address in BURST.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr       <= IDW'(NREQ - 1);
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_own_id    <= '0;
      r_ack       <= '0;
    end else begin
      r_ack <= '0;
      if (w_grant) begin
        r_cur_addr  <= w_win_addr;
        r_remaining <= w_win_len;
        r_own_id    <= w_win;
        r_ptr       <= w_win;
        r_ack       <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
      end else if (r_state == S_BURST) begin
        r_cur_addr  <= r_cur_addr + AW'(1);
        r_remaining <= r_remaining - LW'(1);
      end
    end
  end

  // Readback stage tracks the ROM's one-cycle read latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1    <= 1'b0;
      r_id1   <= '0;
      r_last1 <= 1'b0;
    end else begin
      r_v1    <= w_rom_en;
      r_id1   <= r_own_id;
      r_last1 <= w_rom_en && w_rem_zero;
    end
  end

  assign bus.req_ack  = r_ack;
  assign bus.rom_en   = w_rom_en;
  assign bus.rom_addr = r_cur_addr;
  assign bus.busy     = w_busy;
  assign bus.rd_valid = r_v1;
  assign bus.rd_id    = r_id1;
  assign bus.rd_last  = r_last1;
  assign bus.rd_data  = bus.rom_data;
endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: per-cycle request plans are turned into an
// expected transaction schedule (grant time, word addresses, readback) and compared.
module tb_rom_burst_arbiter;
  localparam int NREQ = 2, AW = 3, DW = 4, LW = 3, IDW = 2;
  localparam int N = 64, NE = N + 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rom_burst_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW), .IDW(IDW)) bus ();

  rom_burst_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW), .IDW(IDW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Synchronous single-port ROM with registered read
  logic [DW-1:0] rom [2**AW];
  logic [DW-1:0] rom_q = '0;
  always @(posedge clk) if (bus.rom_en) rom_q <= rom[bus.rom_addr];
  assign bus.rom_data = rom_q;

  int checks = 0, failures = 0;
  int last_w;
  int a_addr [NREQ];
  int a_len  [NREQ];
  logic [NREQ-1:0] plan [N];
  int e_ack [NE], e_en [NE], e_addr [NE], e_vld [NE], e_data [NE], e_id [NE], e_last [NE];

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"},   0, 32'(bus.req_ack),  0);
    chk({tag, "_en"},    0, 32'(bus.rom_en),   0);
    chk({tag, "_addr"},  0, 32'(bus.rom_addr), 0);
    chk({tag, "_vld"},   0, 32'(bus.rd_valid), 0);
    chk({tag, "_id"},    0, 32'(bus.rd_id),    0);
    chk({tag, "_last"},  0, 32'(bus.rd_last),  0);
    chk({tag, "_busy"},  0, 32'(bus.busy),     0);
  endtask

  task automatic clear_plan();
    for (int c = 0; c < N; c++) plan[c] = '0;
  endtask

  // Transaction schedule: a request visible while idle at cycle i is acked at i+1,
  // issues words at i+1..i+1+len, returns them at i+2.., and the arbiter is idle again at i+2+len.
  function automatic void build_model(input int n);
    int idle, w;
    for (int c = 0; c < NE; c++) begin
      e_ack[c] = 0; e_en[c] = 0; e_addr[c] = 0; e_vld[c] = 0;
      e_data[c] = 0; e_id[c] = 0; e_last[c] = 0;
    end
    idle = 0;
    while (idle < n) begin
      if (plan[idle] != '0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          int cand;
          cand = (last_w + k) % NREQ;
          if (w < 0 && plan[idle][cand]) w = cand;
        end
        last_w = w;
        e_ack[idle+1] = 1 << w;
        for (int k = 0; k <= a_len[w]; k++) begin
          e_en[idle+1+k]   = 1;
          e_addr[idle+1+k] = (a_addr[w] + k) % (2**AW);
          e_vld[idle+2+k]  = 1;
          e_data[idle+2+k] = int'(rom[(a_addr[w] + k) % (2**AW)]);
          e_id[idle+2+k]   = w;
          e_last[idle+2+k] = (k == a_len[w]) ? 1 : 0;
        end
        idle += a_len[w] + 2;
      end else begin
        idle++;
      end
    end
  endfunction

  // Plans must be zero in their last 12 cycles so every burst drains inside the window.
  task automatic run_window(input string tag, input int n);
    build_model(n);
    for (int c = 0; c < n; c++) begin
      chk({tag, "_ack"},  c, 32'(bus.req_ack),  e_ack[c]);
      chk({tag, "_busy"}, c, 32'(bus.busy),     e_en[c]);
      chk({tag, "_en"},   c, 32'(bus.rom_en),   e_en[c]);
      chk({tag, "_vld"},  c, 32'(bus.rd_valid), e_vld[c]);
      chk({tag, "_last"}, c, 32'(bus.rd_last),  e_last[c]);
      if (e_en[c] != 0) chk({tag, "_addr"}, c, 32'(bus.rom_addr), e_addr[c]);
      if (e_vld[c] != 0) begin
        chk({tag, "_data"}, c, 32'(bus.rd_data), e_data[c]);
        chk({tag, "_id"},   c, 32'(bus.rd_id),   e_id[c]);
      end
      bus.req = plan[c];
      for (int i = 0; i < NREQ; i++) begin
        bus.req_addr[i*AW +: AW] = AW'(a_addr[i]);
        bus.req_len[i*LW +: LW]  = LW'(a_len[i]);
      end
      @(posedge clk); #1;
    end
    bus.req = '0;
  endtask

  initial begin
    rom[0] = 4'b0001; rom[1] = 4'b0011; rom[2] = 4'b1010; rom[3] = 4'b0110;
    rom[4] = 4'b0111; rom[5] = 4'b1101; rom[6] = 4'b1001; rom[7] = 4'b1011;
    bus.req = '0; bus.req_addr = '0; bus.req_len = '0;
    for (int i = 0; i < NREQ; i++) begin a_addr[i] = 0; a_len[i] = 0; end

    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_w = NREQ - 1;

    // Contention: both held, single-word bursts alternate 0,1,0,1
    clear_plan();
    a_addr[0] = 5; a_len[0] = 0; a_addr[1] = 6; a_len[1] = 0;
    for (int c = 0; c < 20; c++) plan[c] = 2'b11;
    run_window("contend", 32);

    // Single burst from address 2, three words
    clear_plan();
    a_addr[0] = 2; a_len[0] = 2; plan[0] = 2'b01;
    run_window("single", 16);

    // Address wrap 6,7,0,1
    clear_plan();
    a_addr[1] = 6; a_len[1] = 3; plan[0] = 2'b10;
    run_window("wrap", 18);

    // Maximum length covers the whole ROM
    clear_plan();
    a_addr[0] = 0; a_len[0] = 7; plan[0] = 2'b01;
    run_window("maxlen", 24);

    // req[1] pulses only during a burst, then is held into IDLE
    clear_plan();
    a_addr[0] = 0; a_len[0] = 4; a_addr[1] = 3; a_len[1] = 1;
    plan[0] = 2'b01;
    for (int c = 2; c <= 4; c++) plan[c] = 2'b10;
    plan[20] = 2'b01;
    for (int c = 22; c <= 26; c++) plan[c] = 2'b10;
    run_window("withdraw", 40);

    // Reset during the second word of a six-word burst
    a_addr[0] = 1; a_len[0] = 5;
    bus.req = 2'b01;
    bus.req_addr[0 +: AW] = AW'(1);
    bus.req_len[0 +: LW]  = LW'(5);
    @(posedge clk); #1;
    chk("rst_ack", 1, 32'(bus.req_ack), 1);
    bus.req = '0;
    @(posedge clk); #1;
    chk("rst_word2", 2, 32'(bus.rom_addr), 2);
    #2 rst_n = 1'b0;
    bus.req = 2'b10;
    #1 chk_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_zero("rst_hold");
    end
    rst_n = 1'b1;
    last_w = NREQ - 1;
    clear_plan();
    a_addr[1] = 4; a_len[1] = 2;
    for (int c = 0; c < 3; c++) plan[c] = 2'b10;
    run_window("postrst", 20);

    // Randomized request plans, lengths and bases
    for (int r = 0; r < 10; r++) begin
      clear_plan();
      for (int i = 0; i < NREQ; i++) begin
        a_addr[i] = int'($urandom_range(0, 2**AW - 1));
        a_len[i]  = int'($urandom_range(0, 2**LW - 1));
      end
      for (int c = 0; c < N - 12; c++)
        plan[c] = ($urandom_range(0, 2) == 0) ? '0 : NREQ'($urandom_range(1, 2**NREQ - 1));
      run_window("random", N);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
